branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
- Fetch-side counterpart to the execute-stage branch resolver.
- Consumes resolved outcomes (pc, taken, dest pc, jump flag) to train a direct-mapped BTB with 2-bit saturating counters.
- Answers fetch-stage lookups one cycle later with a predicted next PC.
- Contains an invalidation walker that clears the table after reset or on an explicit flush.

Parameters:
- IDX_W, 6, log2 of BTB entries (ENTRIES = 2**IDX_W).
- TAG_W, 12, tag bits stored per entry.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_flush  in  1  request full table invalidation
- i_fetch_valid  in  1  lookup request
- i_fetch_pc  in  32  lookup PC
- o_pred_valid  out  1  lookup result valid (registered)
- o_pred_taken  out  1  predicted taken
- o_pred_pc  out  32  predicted next PC
- i_upd_valid  in  1  resolved-branch update
- i_upd_pc  in  32  PC of resolved branch/jump
- i_upd_taken  in  1  resolved direction
- i_upd_dest_pc  in  32  resolved target
- i_upd_jump  in  1  unconditional (JAL/JALR)
- o_busy  out  1  invalidation walk in progress

Behaviour:
- Index = pc[IDX_W:1] (2-byte granularity). Tag = pc[IDX_W+TAG_W:IDX_W+1].
- Entry fields: valid, tag, target[31:0], ctr[1:0]. Only the valid bits need reset; the remaining storage may be reset-free RAM.
- FSM states: CLEAR, RUN.
  - Async reset: state=CLEAR, clear_idx=0, o_pred_valid=0, o_pred_taken=0, o_pred_pc=0, o_busy=1.
  - CLEAR: writes valid[clear_idx]=0 each cycle and increments clear_idx. After clear_idx reaches ENTRIES-1 it moves to RUN, so the walk takes exactly ENTRIES cycles.
  - RUN with i_flush=1: back to CLEAR, clear_idx=0.
  - i_flush during CLEAR restarts the walk at clear_idx=0.
- o_busy = (state==CLEAR).
- Lookup, 1-cycle latency: cycle N i_fetch_valid/i_fetch_pc → cycle N+1 o_pred_valid=1.
  - hit = valid && tag match; o_pred_taken = hit && ctr[1].
  - o_pred_pc = o_pred_taken ? target : fetch_pc+4 (32-bit wrap).
  - i_fetch_valid=0 → o_pred_valid=0 next cycle; taken and pc hold their previous values.
  - During CLEAR: lookups still respond with o_pred_valid=1, o_pred_taken=0, o_pred_pc=pc+4.
- Update, applied at clock edge, RUN only (dropped silently during CLEAR):
  - Hit: if i_upd_jump, ctr=2'b11. Otherwise ctr saturating +1 if taken, -1 if not taken (floor 00, ceiling 11). target=i_upd_dest_pc whenever taken.
  - Miss, taken: allocate (overwrite) with valid=1, tag, target=dest, ctr = i_upd_jump ? 2'b11 : 2'b10.
  - Miss, not taken: no change.
- Same-cycle lookup and update to the same index: the lookup returns pre-update contents (read-before-write), unless BRU_BYPASS_EN is defined.
- Same-cycle i_flush and update: flush wins and the update is dropped.

Optional Feature:
- Macro BRU_BYPASS_EN.
- Defined: a lookup coincident with an update to the same index and matching tag sees the post-update entry (new ctr/target/valid), computed combinationally before the output register.
- Undefined: read-before-write as above.

Decomposition:
- Shared package gets:
  - bpu_entry_t struct {valid, tag, target, ctr}
  - bpu_ctr_t enum {STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11}
  - bpu_state_t {BPU_CLEAR, BPU_RUN}
  - program_counter_t reused
- One sub-module: bpu_sat_ctr (combinational 2-bit saturating next-value: ctr, taken, jump → next ctr).

Test Plan:
- Reset then poll: o_busy=1 for exactly 64 cycles (IDX_W=6); lookup pc=0x1000 during walk → taken=0, pred_pc=0x1004.
- Update pc=0x1000 taken dest=0x2000 jump=0, then lookup 0x1000 → taken=1, pred_pc=0x2000 next cycle; lookup 0x1000+0x80 (same index, different tag) → taken=0, pc=0x1084.
- Train 0x1000 taken×3 then not-taken×1 → ctr 11→10, still taken; one more not-taken → 01, lookup taken=0, pc=0x1004.
- Not-taken update on miss pc=0x3000 → subsequent lookup taken=0; jump update pc=0x3000 dest=0x4000 → taken=1, and one not-taken update leaves ctr=10, still taken.
- i_flush pulse after training, re-pulsed 10 cycles into the walk → o_busy stays high 64 cycles after the second pulse; all prior entries miss afterwards.
- Same-cycle update and lookup of 0x5000 (empty entry): without BRU_BYPASS_EN → taken=0; with it → taken=1, pred_pc=dest.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types for the fetch-side branch predictor.
//
// Contents:
//   program_counter_t : 32-bit program counter
//   bpu_ctr_t         : 2-bit saturating direction counter encoding
//   bpu_state_t       : invalidation walker states (BPU_CLEAR / BPU_RUN)
//   bpu_entry_t       : one BTB entry {valid, tag, target, ctr}
//   bpu_seq_pc()      : sequential (not-taken) next PC
//
// The entry struct is sized by BPU_TAG_W, so the TAG_W parameter of
// branch_predictor must keep its default of BPU_TAG_W.
package branch_predictor_pkg;

  localparam int BPU_IDX_W = 6;
  localparam int BPU_TAG_W = 12;

  typedef logic [31:0] program_counter_t;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bpu_ctr_t;

  typedef enum logic {
    BPU_CLEAR = 1'b0,
    BPU_RUN   = 1'b1
  } bpu_state_t;

  typedef struct packed {
    logic                 valid;
    logic [BPU_TAG_W-1:0] tag;
    program_counter_t     target;
    bpu_ctr_t             ctr;
  } bpu_entry_t;

  // Fall-through fetch address; wraps at 32 bits.
  function automatic program_counter_t bpu_seq_pc(input program_counter_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_ctr.sv
// bpu_sat_ctr: combinational next value of a 2-bit saturating counter.
//
// Ports:
//   ctr_i   : current counter value
//   taken_i : resolved direction
//   jump_i  : unconditional jump, forces STRONG_T
//   ctr_o   : next counter value (saturates at STRONG_NT / STRONG_T)
module bpu_sat_ctr
  import branch_predictor_pkg::*;
(
  input  bpu_ctr_t ctr_i,
  input  logic     taken_i,
  input  logic     jump_i,
  output bpu_ctr_t ctr_o
);

  // Step one position towards the resolved direction; jumps always
  // become strongly taken since they can never fall through.
  always_comb begin
    ctr_o = ctr_i;
    if (jump_i) begin
      ctr_o = STRONG_T;
    end else if (taken_i) begin
      case (ctr_i)
        STRONG_NT: ctr_o = WEAK_NT;
        WEAK_NT:   ctr_o = WEAK_T;
        default:   ctr_o = STRONG_T;
      endcase
    end else begin
      case (ctr_i)
        STRONG_T: ctr_o = WEAK_T;
        WEAK_T:   ctr_o = WEAK_NT;
        default:  ctr_o = STRONG_NT;
      endcase
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit direction counters.
//
// Trained by resolved branches from execute, answers fetch lookups with a
// one-cycle registered prediction. An invalidation walker clears every
// valid bit after reset or on i_flush, one entry per cycle.
//
// Ports:
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_flush                 : restart the invalidation walk
//   i_fetch_valid/_pc       : lookup request
//   o_pred_valid/_taken/_pc : registered lookup result
//   i_upd_valid/_pc/_taken/_dest_pc/_jump : resolved branch training
//   o_busy                  : invalidation walk in progress
//
// Build option: define BRU_BYPASS_EN to let a lookup see the result of a
// same-cycle update to the same entry; otherwise reads are read-before-write.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_W = BPU_IDX_W,
  parameter int TAG_W = BPU_TAG_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_fetch_valid,
  input  program_counter_t i_fetch_pc,
  output logic             o_pred_valid,
  output logic             o_pred_taken,
  output program_counter_t o_pred_pc,
  input  logic             i_upd_valid,
  input  program_counter_t i_upd_pc,
  input  logic             i_upd_taken,
  input  program_counter_t i_upd_dest_pc,
  input  logic             i_upd_jump,
  output logic             o_busy
);

  localparam int ENTRIES = 2 ** IDX_W;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [TAG_W-1:0] tag_t;

  bpu_state_t       state_q, state_d;
  idx_t             clearIdx_q, clearIdx_d;
  logic [ENTRIES-1:0] valid_q, valid_d;

  // Reset-free payload storage; only the valid bits carry reset state.
  tag_t             tag_q    [ENTRIES];
  program_counter_t target_q [ENTRIES];
  bpu_ctr_t         ctr_q    [ENTRIES];

  logic             predValid_q, predValid_d;
  logic             predTaken_q, predTaken_d;
  program_counter_t predPc_q, predPc_d;

  idx_t       fetchIdx, updIdx;
  tag_t       fetchTag, updTag;
  bpu_entry_t fetchEntry, updEntry, newEntry;
  bpu_ctr_t   satCtrNext;
  logic       updHit, updEn, wrEn, fetchHit;
  logic       unusedUpdBits;

  assign fetchIdx = i_fetch_pc[IDX_W:1];
  assign fetchTag = i_fetch_pc[IDX_W+TAG_W:IDX_W+1];
  assign updIdx   = i_upd_pc[IDX_W:1];
  assign updTag   = i_upd_pc[IDX_W+TAG_W:IDX_W+1];

  // Bits of the update PC that are neither index nor tag.
  assign unusedUpdBits = ^{i_upd_pc[31:IDX_W+TAG_W+1], i_upd_pc[0]};

  assign updEntry = '{valid:  valid_q[updIdx],
                      tag:    tag_q[updIdx],
                      target: target_q[updIdx],
                      ctr:    ctr_q[updIdx]};
  assign updHit = updEntry.valid && (updEntry.tag == updTag);

  // Training is ignored while the walker owns the table, and a flush in
  // the same cycle takes priority over the update.
  assign updEn = i_upd_valid && (state_q == BPU_RUN) && !i_flush;

  bpu_sat_ctr u_sat_ctr (
    .ctr_i   (updEntry.ctr),
    .taken_i (i_upd_taken),
    .jump_i  (i_upd_jump),
    .ctr_o   (satCtrNext)
  );

  // Build the post-update entry. Hits retrain in place; taken misses
  // allocate over whatever lived there; not-taken misses change nothing.
  always_comb begin
    wrEn     = 1'b0;
    newEntry = updEntry;
    if (updEn) begin
      if (updHit) begin
        wrEn         = 1'b1;
        newEntry.ctr = satCtrNext;
        if (i_upd_taken) begin
          newEntry.target = i_upd_dest_pc;
        end
      end else if (i_upd_taken) begin
        wrEn     = 1'b1;
        newEntry = '{valid:  1'b1,
                     tag:    updTag,
                     target: i_upd_dest_pc,
                     ctr:    (i_upd_jump ? STRONG_T : WEAK_T)};
      end
    end
  end

  // Lookup read port, optionally forwarding a same-cycle write to the
  // same entry and tag.
  always_comb begin
    fetchEntry = '{valid:  valid_q[fetchIdx],
                   tag:    tag_q[fetchIdx],
                   target: target_q[fetchIdx],
                   ctr:    ctr_q[fetchIdx]};
`ifdef BRU_BYPASS_EN
    if (wrEn && (updIdx == fetchIdx) && (updTag == fetchTag)) begin
      fetchEntry = newEntry;
    end
`else
    fetchEntry = fetchEntry;
`endif
  end

  assign fetchHit = fetchEntry.valid && (fetchEntry.tag == fetchTag);

  // Prediction for the output register. While the walk runs every
  // lookup falls through; an idle cycle keeps the last taken/pc.
  always_comb begin
    predValid_d = 1'b0;
    predTaken_d = predTaken_q;
    predPc_d    = predPc_q;
    if (i_fetch_valid) begin
      predValid_d = 1'b1;
      predTaken_d = (state_q == BPU_RUN) && fetchHit &&
                    ((fetchEntry.ctr == WEAK_T) || (fetchEntry.ctr == STRONG_T));
      predPc_d    = predTaken_d ? fetchEntry.target : bpu_seq_pc(i_fetch_pc);
    end
  end

  // Walker / run state machine plus valid-bit maintenance. A flush in
  // either state restarts the walk from entry 0.
  always_comb begin
    state_d    = state_q;
    clearIdx_d = clearIdx_q;
    valid_d    = valid_q;
    case (state_q)
      BPU_CLEAR: begin
        valid_d[clearIdx_q] = 1'b0;
        if (i_flush) begin
          clearIdx_d = '0;
        end else if (clearIdx_q == idx_t'(ENTRIES - 1)) begin
          state_d    = BPU_RUN;
          clearIdx_d = '0;
        end else begin
          clearIdx_d = clearIdx_q + idx_t'(1);
        end
      end
      BPU_RUN: begin
        if (i_flush) begin
          state_d    = BPU_CLEAR;
          clearIdx_d = '0;
        end else if (wrEn) begin
          valid_d[updIdx] = 1'b1;
        end
      end
      default: begin
        state_d    = BPU_CLEAR;
        clearIdx_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= BPU_CLEAR;
      clearIdx_q  <= '0;
      valid_q     <= '0;
      predValid_q <= 1'b0;
      predTaken_q <= 1'b0;
      predPc_q    <= '0;
    end else begin
      state_q     <= state_d;
      clearIdx_q  <= clearIdx_d;
      valid_q     <= valid_d;
      predValid_q <= predValid_d;
      predTaken_q <= predTaken_d;
      predPc_q    <= predPc_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wrEn) begin
      tag_q[updIdx]    <= newEntry.tag;
      target_q[updIdx] <= newEntry.target;
      ctr_q[updIdx]    <= newEntry.ctr;
    end
  end

  assign o_pred_valid = predValid_q;
  assign o_pred_taken = predTaken_q;
  assign o_pred_pc    = predPc_q;
  assign o_busy       = (state_q == BPU_CLEAR);

endmodule
